pc_unit: RTL and testbench

Program-counter and return-address-stack stage of the CPU. Consumes the control unit's `s_inc`, `push` and `pop` strobes plus the jump target field of the current instruction, and produces the registered program counter that addresses instruction memory. Implements sequential fetch, jumps (conditional decision already resolved upstream into `s_inc`), `CALL` and `RET` through an internal LIFO of return addresses.

---
 rtl/pc_unit.sv | 203 ++++++++++++++++++++
 tb/tb_pc_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//
// Program counter and return-address stack for the CPU fetch stage.
// Each cycle performs exactly one action. Priority is push, then pop, then
// s_inc:
//   push  (CALL) : save pc+1 on the stack and load jaddr
//   pop   (RET)  : load the top-of-stack return address
//   s_inc = 1    : sequential fetch, pc+1
//   s_inc = 0    : jump, load jaddr
// The program counter wraps modulo 2^ADDR_W.
//
// Configuration macro: PC_UNIT_STACK_CHECK_EN
//   defined   : the stack guards against full and empty.
//               - A push while full still jumps, but the return address is
//                 dropped and stk_ovf is set.
//               - A pop while empty falls through to pc+1 and sets stk_unf.
//               - sp counts 0..DEPTH.
//   undefined : the stack pointer is $clog2(DEPTH) bits and wraps freely.
//               - Pushing past DEPTH-1 entries overwrites the oldest entries.
//               - Popping at sp == 0 reads entry DEPTH-1.
//               - stk_full, stk_ovf and stk_unf are tied to 0.
//
// Parameters:
//   ADDR_W : pc and return-address width (default 10)
//   DEPTH  : number of return-stack entries. Must be a power of two and at
//            least 2 (default 16).
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset; overrides every strobe
//   s_inc     in   1 = pc+1, 0 = load jaddr (when no push/pop)
//   push      in   CALL strobe
//   pop       in   RET strobe
//   jaddr     in   jump/call target
//   pc        out  registered program counter
//   sp        out  number of valid stack entries
//   stk_empty out  sp == 0
//   stk_full  out  sp == DEPTH (guarded build only)
//   stk_ovf   out  sticky push-while-full flag (guarded build only)
//   stk_unf   out  sticky pop-while-empty flag (guarded build only)
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_inc,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ADDR_W-1:0]      jaddr,
    output logic [ADDR_W-1:0]      pc,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   stk_empty,
    output logic                   stk_full,
    output logic                   stk_ovf,
    output logic                   stk_unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SP_W  = PTR_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_tos;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_rd_idx;
    logic              w_wr_en;

    // Return-address storage. The stack is not reset; only the pointer is.
    logic [ADDR_W-1:0] r_stack [DEPTH];

    // Both the sequential fetch and the saved return address use this
    // wrapping increment.
    assign w_pc_inc = r_pc + ADDR_W'(1);

    // The read is combinational, so a RET issued right after a CALL sees
    // the entry that the CALL wrote on the previous edge.
    assign w_tos = r_stack[w_rd_idx];

`ifdef PC_UNIT_STACK_CHECK_EN
    logic [SP_W-1:0] r_sp;
    logic [SP_W-1:0] w_sp_next;
    logic            r_ovf;
    logic            r_unf;
    logic            w_ovf_next;
    logic            w_unf_next;
    logic            w_full;
    logic            w_empty;

    assign w_full   = (r_sp == SP_W'(DEPTH));
    assign w_empty  = (r_sp == '0);
    // A write only happens when not full, so sp < DEPTH and the low bits
    // index the slot directly.
    assign w_wr_idx = r_sp[PTR_W-1:0];
    // A read only matters when not empty, so sp-1 lies in 0..DEPTH-1.
    assign w_rd_idx = PTR_W'(r_sp - SP_W'(1));

    always_comb begin
        w_pc_next  = w_pc_inc;
        w_sp_next  = r_sp;
        w_wr_en    = 1'b0;
        w_ovf_next = r_ovf;
        w_unf_next = r_unf;
        if (push) begin
            // The jump always happens. Only the return address is at risk.
            w_pc_next = jaddr;
            if (w_full) begin
                w_ovf_next = 1'b1;
            end else begin
                w_wr_en   = 1'b1;
                w_sp_next = r_sp + SP_W'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                // An empty RET falls through to the next instruction.
                w_unf_next = 1'b1;
            end else begin
                w_pc_next = w_tos;
                w_sp_next = r_sp - SP_W'(1);
            end
        end else if (!s_inc) begin
            w_pc_next = jaddr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_sp  <= w_sp_next;
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
        end
    end

    assign sp        = r_sp;
    assign stk_empty = w_empty;
    assign stk_full  = w_full;
    assign stk_ovf   = r_ovf;
    assign stk_unf   = r_unf;
`else
    logic [PTR_W-1:0] r_sp;
    logic [PTR_W-1:0] w_sp_next;

    // The pointer wraps modulo DEPTH in both directions. Popping at 0
    // therefore reads slot DEPTH-1.
    assign w_wr_idx = r_sp;
    assign w_rd_idx = r_sp - PTR_W'(1);

    always_comb begin
        w_pc_next = w_pc_inc;
        w_sp_next = r_sp;
        w_wr_en   = 1'b0;
        if (push) begin
            w_pc_next = jaddr;
            w_wr_en   = 1'b1;
            w_sp_next = r_sp + PTR_W'(1);
        end else if (pop) begin
            w_pc_next = w_tos;
            w_sp_next = r_sp - PTR_W'(1);
        end else if (!s_inc) begin
            w_pc_next = jaddr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
        end else begin
            r_sp <= w_sp_next;
        end
    end

    assign sp        = {1'b0, r_sp};
    assign stk_empty = (r_sp == '0);
    assign stk_full  = 1'b0;
    assign stk_ovf   = 1'b0;
    assign stk_unf   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // A CALL that coincides with reset must not leave a stale entry behind.
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
//
// Testbench for pc_unit, organised in three phases:
//   1. A directed vector table: fetch, jump, wrap, call/return, nested calls,
//      back-to-back CALL/RET, push+pop conflict, and reset during a CALL.
//   2. Hand-written overflow and underflow sequences, matching whichever
//      stack configuration is built.
//   3. Random traffic checked against a queue-based model of the stack.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 16;
    localparam int AMOD   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_inc;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] jaddr;
    logic [ADDR_W-1:0] pc;
    logic [4:0]        sp;
    logic              stk_empty;
    logic              stk_full;
    logic              stk_ovf;
    logic              stk_unf;

    int checks = 0;
    int errors = 0;

    pc_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_inc     (s_inc),
        .push      (push),
        .pop       (pop),
        .jaddr     (jaddr),
        .pc        (pc),
        .sp        (sp),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

`ifdef PC_UNIT_STACK_CHECK_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic       r;
        logic       si;
        logic       pu;
        logic       po;
        logic [9:0] ja;
        int         epc;
        int         esp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one instruction and sample after the edge has settled.
    task automatic step(input logic r, input logic si, input logic pu,
                        input logic po, input logic [ADDR_W-1:0] ja);
        reset = r;
        s_inc = si;
        push  = pu;
        pop   = po;
        jaddr = ja;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input int epc, input int esp,
                              input int eovf, input int eunf);
        $display("%s: pc=%03h sp=%0d empty=%0d full=%0d ovf=%0d unf=%0d",
                 tag, pc, sp, stk_empty, stk_full, stk_ovf, stk_unf);
        check({tag, " pc"}, int'(pc), epc);
        check({tag, " sp"}, int'(sp), esp);
        check({tag, " empty"}, int'(stk_empty), (esp == 0) ? 1 : 0);
        check({tag, " full"}, int'(stk_full), (GUARD && esp == DEPTH) ? 1 : 0);
        check({tag, " ovf"}, int'(stk_ovf), GUARD ? eovf : 0);
        check({tag, " unf"}, int'(stk_unf), GUARD ? eunf : 0);
    endtask

    function automatic void add(input logic r, input logic si, input logic pu,
                                input logic po, input logic [9:0] ja,
                                input int epc, input int esp);
        vec_t v;
        v.r = r; v.si = si; v.pu = pu; v.po = po; v.ja = ja;
        v.epc = epc; v.esp = esp;
        vecs.push_back(v);
    endfunction

    // Reference model state for the random phase.
    int m_pc;
    int m_ovf;
    int m_unf;
    int m_q[$];
    int m_mem[DEPTH];
    int m_cnt;

    function automatic void model_step(input bit r, input bit si, input bit pu,
                                       input bit po, input int ja);
        int inc;
        inc = (m_pc + 1) % AMOD;
        if (r) begin
            m_pc = 0; m_q.delete(); m_cnt = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        if (GUARD) begin
            if (pu) begin
                if (m_q.size() < DEPTH) m_q.push_back(inc);
                else m_ovf = 1;
                m_pc = ja;
            end else if (po) begin
                if (m_q.size() > 0) m_pc = m_q.pop_back();
                else begin m_unf = 1; m_pc = inc; end
            end else begin
                m_pc = si ? inc : ja;
            end
        end else begin
            if (pu) begin
                m_mem[m_cnt] = inc;
                m_cnt = (m_cnt + 1) % DEPTH;
                m_pc = ja;
            end else if (po) begin
                m_cnt = (m_cnt + DEPTH - 1) % DEPTH;
                m_pc = m_mem[m_cnt];
            end else begin
                m_pc = si ? inc : ja;
            end
        end
    endfunction

    function automatic int model_sp();
        return GUARD ? m_q.size() : m_cnt;
    endfunction

    initial begin
        reset = 1'b1; s_inc = 1'b0; push = 1'b0; pop = 1'b0; jaddr = '0;

        // ---------------- Phase 1: directed vector table ----------------
        //   r  si pu po ja      pc      sp
        add(1, 0, 0, 0, 10'h000, 'h000, 0);
        add(1, 0, 0, 0, 10'h000, 'h000, 0);
        add(0, 1, 0, 0, 10'h0F0, 'h001, 0);
        add(0, 1, 0, 0, 10'h0F0, 'h002, 0);
        add(0, 1, 0, 0, 10'h0F0, 'h003, 0);
        add(0, 1, 0, 0, 10'h0F0, 'h004, 0);
        add(0, 1, 0, 0, 10'h0F0, 'h005, 0);
        add(0, 0, 0, 0, 10'h120, 'h120, 0);   // jump
        add(0, 1, 0, 0, 10'h0F0, 'h121, 0);
        add(0, 0, 0, 0, 10'h3FF, 'h3FF, 0);
        add(0, 1, 0, 0, 10'h0F0, 'h000, 0);   // pc wraps
        add(0, 0, 0, 0, 10'h010, 'h010, 0);
        add(0, 1, 1, 0, 10'h200, 'h200, 1);   // CALL
        add(0, 1, 0, 0, 10'h0F0, 'h201, 1);
        add(0, 1, 0, 0, 10'h0F0, 'h202, 1);
        add(0, 1, 0, 1, 10'h0F0, 'h011, 0);   // RET
        add(0, 0, 0, 0, 10'h010, 'h010, 0);   // nested calls
        add(0, 1, 1, 0, 10'h200, 'h200, 1);
        add(0, 1, 0, 0, 10'h0F0, 'h201, 1);
        add(0, 1, 1, 0, 10'h300, 'h300, 2);
        add(0, 1, 0, 0, 10'h0F0, 'h301, 2);
        add(0, 1, 1, 0, 10'h380, 'h380, 3);
        add(0, 1, 0, 1, 10'h0F0, 'h302, 2);
        add(0, 1, 0, 1, 10'h0F0, 'h202, 1);
        add(0, 1, 0, 1, 10'h0F0, 'h011, 0);
        add(0, 1, 1, 0, 10'h155, 'h155, 1);   // back-to-back CALL/RET
        add(0, 1, 0, 1, 10'h0F0, 'h012, 0);
        add(0, 0, 0, 0, 10'h003, 'h003, 0);   // push+pop conflict
        add(0, 1, 1, 1, 10'h0AA, 'h0AA, 1);
        add(0, 1, 0, 1, 10'h0F0, 'h004, 0);   // stacked value was 4
        add(0, 1, 1, 0, 10'h100, 'h100, 1);
        add(1, 1, 1, 0, 10'h2AA, 'h000, 0);   // reset with CALL
        add(0, 1, 0, 0, 10'h0F0, 'h001, 0);
        add(0, 0, 0, 0, 10'h3FF, 'h3FF, 0);
        add(0, 1, 1, 0, 10'h040, 'h040, 1);   // return address wraps
        add(0, 1, 0, 1, 10'h0F0, 'h000, 0);
        add(1, 0, 0, 0, 10'h000, 'h000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].si, vecs[i].pu, vecs[i].po, vecs[i].ja);
            expect_all($sformatf("vec%0d", i), vecs[i].epc, vecs[i].esp, 0, 0);
        end

        // -------- Phase 2: overflow / underflow sequences --------
        // Push k (k = 0..15) happens at pc 0 for k = 0 and at 0x100+k-1
        // otherwise, so it saves 1 for k = 0 and 0x100+k otherwise.
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 1, 1, 0, ADDR_W'(32'h100 + k));
            expect_all($sformatf("fill%0d", k), 'h100 + k,
                       GUARD ? k + 1 : (k + 1) % DEPTH, 0, 0);
        end
        if (GUARD) begin
            step(0, 1, 1, 0, 10'h050);
            expect_all("push_full", 'h050, 16, 1, 0);
            for (int k = DEPTH - 1; k >= 0; k--) begin
                step(0, 1, 0, 1, 10'h0F0);
                expect_all($sformatf("drain%0d", k), (k == 0) ? 'h001 : 'h100 + k,
                           k, 1, 0);
            end
            step(0, 1, 0, 1, 10'h0F0);
            expect_all("pop_empty", 'h002, 0, 1, 1);
            step(1, 0, 0, 0, 10'h000);
            expect_all("clr_flags", 'h000, 0, 0, 0);
            step(0, 0, 0, 0, 10'h007);
            expect_all("jump7", 'h007, 0, 0, 0);
            step(0, 1, 0, 1, 10'h0F0);
            expect_all("unf_at7", 'h008, 0, 0, 1);
        end else begin
            // Slot 0 is overwritten with 0x10F+1; slot 15 still holds 0x10F.
            step(0, 1, 1, 0, 10'h050);
            expect_all("push_wrap", 'h050, 1, 0, 0);
            step(0, 1, 0, 1, 10'h0F0);
            expect_all("pop_over", 'h110, 0, 0, 0);
            step(0, 1, 0, 1, 10'h0F0);
            expect_all("pop_wrap", 'h10F, 15, 0, 0);
        end

        // ---------------- Phase 3: randomized traffic ----------------
        for (int c = 0; c < 1200; c++) begin
            bit r, si, pu, po;
            int ja;
            r  = (c == 0) || ($urandom_range(0, 63) == 0);
            si = $urandom_range(0, 1) == 1;
            pu = $urandom_range(0, 4) == 0;
            po = $urandom_range(0, 3) == 0;
            ja = $urandom_range(0, AMOD - 1);
            // Fill every slot first so wrapped reads see known contents.
            if (c >= 1 && c <= DEPTH) begin
                r = 1'b0; pu = 1'b1;
            end
            if (c > DEPTH && c < DEPTH + 40) begin
                r = 1'b0; pu = 1'b0; po = 1'b1;
            end
            step(r, si, pu, po, ADDR_W'(ja));
            model_step(r, si, pu, po, ja);
            expect_all($sformatf("rnd%0d", c), m_pc, model_sp(), m_ovf, m_unf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
